// File: rtl/gray_counter_if.sv
// Bundled control/status signals for gray_counter.
// err is present only when GRAY_CHECK_EN is defined.
interface gray_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
`ifdef GRAY_CHECK_EN
    logic             err;

    modport master (output en, up, load, load_val, input gray_out, tc, err);
    modport slave  (input en, up, load, load_val, output gray_out, tc, err);
`else
    modport master (output en, up, load, load_val, input gray_out, tc);
    modport slave  (input en, up, load, load_val, output gray_out, tc);
`endif
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with load, registered Gray output and one-cycle wrap pulse.
// Defining GRAY_CHECK_EN adds a sticky single-bit-step checker on gray_out (err).
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    gray_counter_if.slave bus
);
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;

    // Load wins over counting; tc only flags a count that wraps.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                bin_d = bin_q + WIDTH'(1);
                tc_d  = &bin_q;
            end else begin
                bin_d = bin_q - WIDTH'(1);
                tc_d  = ~|bin_q;
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.gray_out = gray_q;
    assign bus.tc       = tc_q;

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] diff;
    logic             first_q;
    logic             err_q;
    logic             bad;

    // gray_q is the previous output; a legal count step flips exactly one bit.
    always_comb begin
        diff = gray_q ^ gray_d;
        bad  = !bus.load && bus.en && !first_q &&
               ((diff == '0) || ((diff & (diff - WIDTH'(1))) != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            first_q <= 1'b0;
            err_q   <= err_q | bad;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits; legal range is 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-007 SHALL have port load_val, input, WIDTH bits: binary value to load.
REQ-008 SHALL have port gray_out, output, WIDTH bits: registered Gray-coded count, for the downstream Gray-to-binary converter stage.
REQ-009 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count (wrap) pulse.
REQ-010 SHALL have port err, output, 1 bit: sticky Gray-sequence violation flag; present only with GRAY_CHECK_EN.

Function
REQ-011 SHALL hold an internal WIDTH-bit binary count bin; gray_out SHALL always equal the registered value of bin ^ (bin >> 1).
REQ-012 SHALL update bin and gray_out on the same clk edge, with no extra pipeline stage: an input sampled at edge N is reflected on gray_out after edge N.
REQ-013 SHALL give load priority over en: with load=1, bin <= load_val regardless of en and up.
REQ-014 SHALL, with load=0 and en=1, set bin <= bin+1 when up=1 and bin <= bin-1 when up=0, modulo 2^WIDTH.
REQ-015 SHALL hold bin, gray_out and all flags constant when load=0 and en=0, except that tc returns to 0.
REQ-016 SHALL wrap from all-ones to 0 when counting up and from 0 to all-ones when counting down.
REQ-017 SHALL assert tc for exactly one cycle, registered together with the gray_out update, when a count (not a load) wraps as in REQ-016; tc SHALL be 0 in all other cycles.
REQ-018 SHALL NOT assert tc on a load, even when load_val is 0 or all-ones.
REQ-019 SHALL apply a direction change, with en held high, on the very next edge, with no dead cycle.
REQ-020 SHALL, for simultaneous load and en at the wrap boundary, take the load only and leave tc at 0.

Reset
REQ-021 SHALL, while rst=1, force bin=0, gray_out=0, tc=0 and err=0 immediately, independent of clk.
REQ-022 SHALL, on rst assertion mid-count, abandon any pending update; the first edge after rst deasserts SHALL act on the inputs from the reset value 0.
REQ-023 SHALL NOT require a clock edge for outputs to reach their reset values.

Configuration
REQ-024 SHALL implement the sequence checker only when the macro GRAY_CHECK_EN is defined.
REQ-025 SHALL, with GRAY_CHECK_EN defined, register the previous gray_out and set err to 1 when a count step (en=1, load=0) leaves previous and new gray_out differing in other than exactly one bit.
REQ-026 SHALL, with GRAY_CHECK_EN defined, exclude load cycles and the first cycle after reset from the check.
REQ-027 SHALL, with GRAY_CHECK_EN defined, keep err set once set until rst.
REQ-028 SHALL, without GRAY_CHECK_EN, omit the err port and all checker logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: WIDTH=4, rst pulse then en=1, up=1 for 16 cycles -> gray_out 0000,0001,0011,0010,0110,...,1000 then 0000; tc=1 only with the 0000 after 1000.
REQ-030 SHALL cover: load=1, load_val=0000, then en=1, up=0 -> gray_out 0000 then 1000 with tc=1; the load cycle has tc=0.
REQ-031 SHALL cover: load=1 and en=1 in the same cycle with load_val=0101 while bin=1111 -> gray_out 0111, tc=0.
REQ-032 SHALL cover: counting up to bin=0110 (gray 0101), then rst asserted between edges -> gray_out=0000 immediately; next edge with en=1, up=1 -> 0001.
REQ-033 SHALL cover: en=0 for 5 cycles at gray 0011 -> gray_out stays 0011 and tc=0 throughout.
REQ-034 SHALL cover, with GRAY_CHECK_EN: a full 2^WIDTH up/down sweep with random loads -> err stays 0; a forced internal bin corruption causing a 2-bit change -> err=1 and held until rst.
